// File: rtl/gpu_pkg.sv
// Shared types and default geometry for the shader array sequencer slice.
package gpu_pkg;

  localparam int unsigned DEF_ROWS         = 8;
  localparam int unsigned DEF_COLS         = 8;
  localparam int unsigned DEF_ROW_BITS     = 8;
  localparam int unsigned DEF_COL_BITS     = 8;
  localparam int unsigned DEF_COORD_BITS   = 8;
  localparam int unsigned DEF_PALETTE_BITS = 8;
  localparam int unsigned DEF_PIXEL_BITS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RAST  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_SHADE = 3'd4,
    ST_SWAIT = 3'd5,
    ST_READ  = 3'd6,
    ST_DONE  = 3'd7
  } seq_state_t;

endpackage

// File: rtl/shader_array_sequencer_scanner.sv
// Raster-order row/col walker over the shared pixel bus with a one-deep
// valid/ready output register; idles at (0,0) with pix_* cleared while go is low.
module pixel_readout_scanner
  import gpu_pkg::*;
#(
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROW_BITS   = DEF_ROW_BITS,
  parameter int unsigned COL_BITS   = DEF_COL_BITS,
  parameter int unsigned PIXEL_BITS = DEF_PIXEL_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  go,
  output logic                  done,
  output logic [ROW_BITS-1:0]   row,
  output logic [COL_BITS-1:0]   col,
  input  logic [PIXEL_BITS-1:0] pixel_in,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [PIXEL_BITS-1:0] pix_data,
  output logic [ROW_BITS-1:0]   pix_row,
  output logic [COL_BITS-1:0]   pix_col,
  output logic                  pix_last
);

  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);

  logic [ROW_BITS-1:0]   row_r;
  logic [COL_BITS-1:0]   col_r;
  logic                  issued_all_r;
  logic                  pix_valid_r;
  logic [PIXEL_BITS-1:0] pix_data_r;
  logic [ROW_BITS-1:0]   pix_row_r;
  logic [COL_BITS-1:0]   pix_col_r;
  logic                  pix_last_r;

  logic at_end_s;
  logic hs_s;
  logic cap_s;
  logic done_s;

  // Handshake, capture and end-of-frame decode for the current cycle.
  always_comb begin
    at_end_s = 1'b0;
    hs_s     = 1'b0;
    cap_s    = 1'b0;
    done_s   = 1'b0;
    at_end_s = (row_r == ROW_MAX) && (col_r == COL_MAX);
    hs_s     = pix_valid_r && pix_ready;
    cap_s    = go && !issued_all_r && (!pix_valid_r || pix_ready);
    done_s   = go && hs_s && pix_last_r;
  end

  // Address counter and output register; a stalled pixel holds everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_r        <= '0;
      col_r        <= '0;
      issued_all_r <= 1'b0;
      pix_valid_r  <= 1'b0;
      pix_data_r   <= '0;
      pix_row_r    <= '0;
      pix_col_r    <= '0;
      pix_last_r   <= 1'b0;
    end else if (!go) begin
      row_r        <= '0;
      col_r        <= '0;
      issued_all_r <= 1'b0;
      pix_valid_r  <= 1'b0;
      pix_data_r   <= '0;
      pix_row_r    <= '0;
      pix_col_r    <= '0;
      pix_last_r   <= 1'b0;
    end else if (cap_s) begin
      pix_valid_r  <= 1'b1;
      pix_data_r   <= pixel_in;
      pix_row_r    <= row_r;
      pix_col_r    <= col_r;
      pix_last_r   <= at_end_s;
      issued_all_r <= at_end_s;
      if (col_r == COL_MAX) begin
        col_r <= '0;
        row_r <= (row_r == ROW_MAX) ? '0 : row_r + ROW_BITS'(1);
      end else begin
        col_r <= col_r + COL_BITS'(1);
      end
    end else if (hs_s) begin
      pix_valid_r <= 1'b0;
    end else begin
      pix_valid_r <= pix_valid_r;
    end
  end

  assign done      = done_s;
  assign row       = row_r;
  assign col       = col_r;
  assign pix_valid = pix_valid_r;
  assign pix_data  = pix_data_r;
  assign pix_row   = pix_row_r;
  assign pix_col   = pix_col_r;
  assign pix_last  = pix_last_r;

endmodule

// File: rtl/shader_array_sequencer.sv
// Frame controller for the pixel shader array: broadcasts voxels, triggers
// shading, then streams every pixel out toward the framebuffer writer.
module shader_array_sequencer
  import gpu_pkg::*;
#(
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned ROW_BITS     = DEF_ROW_BITS,
  parameter int unsigned COL_BITS     = DEF_COL_BITS,
  parameter int unsigned COORD_BITS   = DEF_COORD_BITS,
  parameter int unsigned PALETTE_BITS = DEF_PALETTE_BITS,
  parameter int unsigned PIXEL_BITS   = DEF_PIXEL_BITS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  input  logic                    vox_valid,
  output logic                    vox_ready,
  input  logic                    vox_last,
  input  logic [COORD_BITS-1:0]   vox_x,
  input  logic [COORD_BITS-1:0]   vox_y,
  input  logic [COORD_BITS-1:0]   vox_z,
  input  logic [PALETTE_BITS-1:0] vox_id,
  output logic                    do_rasterize,
  output logic                    do_shade,
  output logic [COORD_BITS-1:0]   voxel_x,
  output logic [COORD_BITS-1:0]   voxel_y,
  output logic [COORD_BITS-1:0]   voxel_z,
  output logic [PALETTE_BITS-1:0] voxel_id,
  input  logic                    rast_done_all,
  input  logic                    shade_done_all,
  output logic [ROW_BITS-1:0]     row,
  output logic [COL_BITS-1:0]     col,
  input  logic [PIXEL_BITS-1:0]   pixel_in,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [PIXEL_BITS-1:0]   pix_data,
  output logic [ROW_BITS-1:0]     pix_row,
  output logic [COL_BITS-1:0]     pix_col,
  output logic                    pix_last
);

  seq_state_t              state_r;
  logic                    busy_r;
  logic                    frame_done_r;
  logic                    vox_ready_r;
  logic                    do_rast_r;
  logic                    do_shade_r;
  logic [COORD_BITS-1:0]   voxel_x_r;
  logic [COORD_BITS-1:0]   voxel_y_r;
  logic [COORD_BITS-1:0]   voxel_z_r;
  logic [PALETTE_BITS-1:0] voxel_id_r;
  logic                    last_r;
  logic                    first_r;
  logic                    scan_go_s;
  logic                    scan_done_s;

  assign scan_go_s = (state_r == ST_READ);

  // Frame sequencing; first_r masks the done inputs in the first wait cycle
  // because the array's done flags may still reflect the previous command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      vox_ready_r  <= 1'b0;
      do_rast_r    <= 1'b0;
      do_shade_r   <= 1'b0;
      voxel_x_r    <= '0;
      voxel_y_r    <= '0;
      voxel_z_r    <= '0;
      voxel_id_r   <= '0;
      last_r       <= 1'b0;
      first_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_FETCH;
            busy_r      <= 1'b1;
            vox_ready_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (vox_valid && vox_ready_r) begin
            voxel_x_r   <= vox_x;
            voxel_y_r   <= vox_y;
            voxel_z_r   <= vox_z;
            voxel_id_r  <= vox_id;
            last_r      <= vox_last;
            vox_ready_r <= 1'b0;
            do_rast_r   <= 1'b1;
            state_r     <= ST_RAST;
          end
        end
        ST_RAST: begin
          do_rast_r <= 1'b0;
          first_r   <= 1'b1;
          state_r   <= ST_RWAIT;
        end
        ST_RWAIT: begin
          first_r <= 1'b0;
          if (!first_r && rast_done_all) begin
            if (last_r) begin
              do_shade_r <= 1'b1;
              state_r    <= ST_SHADE;
            end else begin
              vox_ready_r <= 1'b1;
              state_r     <= ST_FETCH;
            end
          end
        end
        ST_SHADE: begin
          do_shade_r <= 1'b0;
          first_r    <= 1'b1;
          state_r    <= ST_SWAIT;
        end
        ST_SWAIT: begin
          first_r <= 1'b0;
          if (!first_r && shade_done_all) begin
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          if (scan_done_s) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
            state_r      <= ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          vox_ready_r  <= 1'b0;
          do_rast_r    <= 1'b0;
          do_shade_r   <= 1'b0;
          first_r      <= 1'b0;
        end
      endcase
    end
  end

  pixel_readout_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .ROW_BITS   (ROW_BITS),
    .COL_BITS   (COL_BITS),
    .PIXEL_BITS (PIXEL_BITS)
  ) u_scanner (
    .clock     (clock),
    .reset_n   (reset_n),
    .go        (scan_go_s),
    .done      (scan_done_s),
    .row       (row),
    .col       (col),
    .pixel_in  (pixel_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_last  (pix_last)
  );

  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign vox_ready    = vox_ready_r;
  assign do_rasterize = do_rast_r;
  assign do_shade     = do_shade_r;
  assign voxel_x      = voxel_x_r;
  assign voxel_y      = voxel_y_r;
  assign voxel_z      = voxel_z_r;
  assign voxel_id     = voxel_id_r;

endmodule
